// File: rtl/spi_clkgen.sv
// spi_clkgen: SPI master clock and chip-select sequencer.
//
// A frame runs through IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE. The
// frame settings are captured on an accepted start, so later input changes
// do not disturb the frame in progress. All outputs are registered.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             one-cycle frame request (accepted only in IDLE)
//   abort             ends any frame in progress on the next cycle
//   cs_sel            chip select to assert for the frame
//   cpol, cpha        SPI mode bits
//   div               SCK half-period = div+1 clk cycles
//   nbits             bits per frame (0 means 1)
//   csn_setup/hold/gap  phase lengths, value+1 clk cycles each
//   sck               serial clock
//   csn               active-low chip selects
//   busy              high while a frame is running
//   done              one-cycle pulse when a frame completes normally
//   sample_en         high in the cycle a sampling edge appears on sck
//   shift_en          high in the cycle a shifting edge appears on sck
module spi_clkgen #(
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 6,
  parameter int DLY_W  = 4,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  div,
  input  logic [CNT_W-1:0]  nbits,
  input  logic [DLY_W-1:0]  csn_setup,
  input  logic [DLY_W-1:0]  csn_hold,
  input  logic [DLY_W-1:0]  csn_gap,
  output logic              sck,
  output logic [NUM_CS-1:0] csn,
  output logic              busy,
  output logic              done,
  output logic              sample_en,
  output logic              shift_en
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [CS_W:0] NUM_CS_V = (CS_W + 1)'(NUM_CS);

  state_t             state, state_n;
  logic [DIV_W:0]     hcnt, hcnt_n;
  logic [CNT_W:0]     ecnt, ecnt_n;
  logic [DLY_W-1:0]   pcnt, pcnt_n;

  logic [CS_W-1:0]    cs_l;
  logic               cpol_l, cpha_l;
  logic [DIV_W-1:0]   div_l;
  logic [CNT_W-1:0]   nbits_l;
  logic [DLY_W-1:0]   setup_l, hold_l, gap_l;

  logic               sck_n, busy_n, done_n, sample_n, shift_n;
  logic [NUM_CS-1:0]  csn_n;

  logic               start_ok;
  logic [DIV_W:0]     half_len;
  logic [CNT_W-1:0]   n_eff;
  logic [CNT_W:0]     two_n;
  logic [CNT_W:0]     edge_k;
  logic [NUM_CS-1:0]  csn_frame;

  // Derived frame quantities. half_len is one bit wider than div so that
  // div = all ones still yields a full 2^DIV_W half-period.
  always_comb begin
    start_ok  = start && !abort && ({1'b0, cs_sel} < NUM_CS_V);
    half_len  = {1'b0, div_l} + 1'b1;
    n_eff     = (nbits_l == '0) ? CNT_W'(1) : nbits_l;
    two_n     = {n_eff, 1'b0};
    edge_k    = ecnt + 1'b1;
    csn_frame = '1;
    csn_frame[cs_l] = 1'b0;
  end

  // Next-state and next-output logic. Outputs are computed here as the value
  // they must show in the following cycle, so each strobe registers together
  // with the sck level it belongs to.
  always_comb begin
    state_n  = state;
    hcnt_n   = hcnt;
    ecnt_n   = ecnt;
    pcnt_n   = pcnt;
    sck_n    = sck;
    csn_n    = csn;
    busy_n   = busy;
    done_n   = 1'b0;
    sample_n = 1'b0;
    shift_n  = 1'b0;

    if (state != IDLE && abort) begin
      state_n = IDLE;
      sck_n   = cpol_l;
      csn_n   = '1;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          sck_n  = cpol;
          csn_n  = '1;
          busy_n = 1'b0;
          if (start_ok) begin
            state_n        = SETUP;
            pcnt_n         = '0;
            csn_n[cs_sel]  = 1'b0;
            busy_n         = 1'b1;
          end
        end

        SETUP: begin
          sck_n = cpol_l;
          if (pcnt == setup_l) begin
            state_n = XFER;
            hcnt_n  = (DIV_W + 1)'(1);
            ecnt_n  = '0;
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end

        // Each half-period ends with an sck toggle; edge_k numbers the toggle
        // about to appear. The last toggle returns sck to cpol and coincides
        // with the first HOLD cycle.
        XFER: begin
          if (hcnt == half_len) begin
            sck_n  = ~sck;
            hcnt_n = (DIV_W + 1)'(1);
            ecnt_n = edge_k;
            if (cpha_l) begin
              shift_n  = edge_k[0];
              sample_n = ~edge_k[0];
            end else begin
              sample_n = edge_k[0];
              shift_n  = ~edge_k[0] && (edge_k != two_n);
            end
            if (edge_k == two_n) begin
              state_n = HOLD;
              pcnt_n  = '0;
            end
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end

        HOLD: begin
          if (pcnt == hold_l) begin
            state_n = GAP;
            pcnt_n  = '0;
            csn_n   = '1;
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end

        GAP: begin
          if (pcnt == gap_l) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end

        default: begin
          state_n = IDLE;
          sck_n   = cpol_l;
          csn_n   = '1;
          busy_n  = 1'b0;
        end
      endcase
    end

    if (state == SETUP || state == XFER || state == HOLD) begin
      if (state_n != IDLE && !(state == HOLD && state_n == GAP)) begin
        csn_n = csn_frame;
      end
    end
  end

  // State, counters, outputs and captured frame settings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      ecnt      <= '0;
      pcnt      <= '0;
      sck       <= 1'b0;
      csn       <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      sample_en <= 1'b0;
      shift_en  <= 1'b0;
      cs_l      <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      div_l     <= '0;
      nbits_l   <= '0;
      setup_l   <= '0;
      hold_l    <= '0;
      gap_l     <= '0;
    end else begin
      state     <= state_n;
      hcnt      <= hcnt_n;
      ecnt      <= ecnt_n;
      pcnt      <= pcnt_n;
      sck       <= sck_n;
      csn       <= csn_n;
      busy      <= busy_n;
      done      <= done_n;
      sample_en <= sample_n;
      shift_en  <= shift_n;
      if (state == IDLE && start_ok) begin
        cs_l    <= cs_sel;
        cpol_l  <= cpol;
        cpha_l  <= cpha;
        div_l   <= div;
        nbits_l <= nbits;
        setup_l <= csn_setup;
        hold_l  <= csn_hold;
        gap_l   <= csn_gap;
      end
    end
  end

endmodule

// File: tb/tb_spi_clkgen.sv
// tb_spi_clkgen: scoreboard bench for spi_clkgen (NUM_CS = 3 so that an
// out-of-range cs_sel can be driven). Stimulus pushes hand-computed strobe
// and done events; a negedge monitor pops and compares them as they appear.
module tb_spi_clkgen;

  localparam int NUM_CS = 3;
  localparam int CS_W   = 2;

  logic              clk, rst, start, abort, cpol, cpha;
  logic [CS_W-1:0]   cs_sel;
  logic [7:0]        div;
  logic [5:0]        nbits;
  logic [3:0]        csn_setup, csn_hold, csn_gap;
  logic              sck, busy, done, sample_en, shift_en;
  logic [NUM_CS-1:0] csn;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  localparam logic [2:0] K_SAMPLE = 3'b001;
  localparam logic [2:0] K_SHIFT  = 3'b010;
  localparam logic [2:0] K_DONE   = 3'b100;

  typedef struct packed {
    logic [31:0]       when;
    logic [2:0]        kind;
    logic              sck;
    logic [NUM_CS-1:0] csn;
    logic              busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_act;

  spi_clkgen #(.NUM_CS(NUM_CS), .DIV_W(8), .CNT_W(6), .DLY_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .div(div), .nbits(nbits),
    .csn_setup(csn_setup), .csn_hold(csn_hold), .csn_gap(csn_gap),
    .sck(sck), .csn(csn), .busy(busy), .done(done),
    .sample_en(sample_en), .shift_en(shift_en)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number; cycle c is the interval after the c-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe or done pulse must match the next queued event
  always @(negedge clk) begin
    if (!rst && (sample_en || shift_en || done)) begin
      mon_act = '{when: cyc, kind: {done, shift_en, sample_en},
                  sck: sck, csn: csn, busy: busy};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_event: got %0h expected none (cycle %0d)",
                 mon_act, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("event", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  task automatic pushExp(input int off, input logic [2:0] kind, input logic s,
                         input logic [NUM_CS-1:0] c, input logic b);
    exp_q.push_back('{when: t0 + off, kind: kind, sck: s, csn: c, busy: b});
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start for one cycle with the given settings, then scrambles the
  // settings to show the running frame ignores them. t0 is the start cycle.
  task automatic applyStimulus(input logic [CS_W-1:0] cs, input logic pol,
                               input logic pha, input logic [7:0] d,
                               input logic [5:0] nb, input logic [3:0] su,
                               input logic [3:0] ho, input logic [3:0] ga);
    cs_sel = cs; cpol = pol; cpha = pha; div = d; nbits = nb;
    csn_setup = su; csn_hold = ho; csn_gap = ga;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    cs_sel = ~cs; cpha = ~pha; div = 8'd7; nbits = 6'd9;
    csn_setup = 4'd3; csn_hold = 4'd5; csn_gap = 4'd2;
  endtask

  task automatic drainCheck(input string name);
    checkOutput(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cpol = 1'b0; cpha = 1'b0;
    cs_sel = '0; div = '0; nbits = '0;
    csn_setup = '0; csn_hold = '0; csn_gap = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_sck", 64'(sck), 64'd0);
    checkOutput("reset_csn", 64'(csn), 64'b111);
    checkOutput("reset_flags", 64'({busy, done, sample_en, shift_en}), 64'd0);

    // Release reset with cpol=1: sck follows on the first edge
    @(posedge clk);
    #1;
    rst = 1'b0; cpol = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_sck", 64'(sck), 64'd1);
    cpol = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_sck_follow", 64'(sck), 64'd0);

    // Basic mode-0 frame on cs 2, with a rejected start during XFER
    applyStimulus(2'd2, 1'b0, 1'b0, 8'd1, 6'd2, 4'd0, 4'd0, 4'd0);
    pushExp(4,  K_SAMPLE, 1'b1, 3'b011, 1'b1);
    pushExp(6,  K_SHIFT,  1'b0, 3'b011, 1'b1);
    pushExp(8,  K_SAMPLE, 1'b1, 3'b011, 1'b1);
    pushExp(12, K_DONE,   1'b0, 3'b111, 1'b0);
    checkOutput("basic_c1_csn_busy", 64'({csn, busy}), 64'({3'b011, 1'b1}));
    waitUntil(t0 + 3);
    start = 1'b1; cs_sel = 2'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitUntil(t0 + 10);
    checkOutput("basic_c10_csn_sck", 64'({csn, sck}), 64'({3'b011, 1'b0}));
    waitUntil(t0 + 11);
    checkOutput("basic_c11_csn_busy", 64'({csn, busy}), 64'({3'b111, 1'b1}));
    waitUntil(t0 + 12);

    // Mode 3 started in the done cycle of the previous frame
    applyStimulus(2'd1, 1'b1, 1'b1, 8'd1, 6'd2, 4'd0, 4'd0, 4'd0);
    pushExp(4,  K_SHIFT,  1'b0, 3'b101, 1'b1);
    pushExp(6,  K_SAMPLE, 1'b1, 3'b101, 1'b1);
    pushExp(8,  K_SHIFT,  1'b0, 3'b101, 1'b1);
    pushExp(10, K_SAMPLE, 1'b1, 3'b101, 1'b1);
    pushExp(12, K_DONE,   1'b1, 3'b111, 1'b0);
    checkOutput("mode3_c1_sck", 64'(sck), 64'd1);
    waitUntil(t0 + 11);
    checkOutput("mode3_c11_csn", 64'(csn), 64'b111);
    waitUntil(t0 + 14);
    drainCheck("drain_basic_mode3");

    // Out-of-range cs_sel, then start together with abort: both ignored
    cpol = 1'b0;
    applyStimulus(2'd3, 1'b0, 1'b0, 8'd1, 6'd2, 4'd0, 4'd0, 4'd0);
    checkOutput("bad_cs_ignored", 64'({csn, busy}), 64'({3'b111, 1'b0}));
    abort = 1'b1;
    applyStimulus(2'd0, 1'b0, 1'b0, 8'd1, 6'd2, 4'd0, 4'd0, 4'd0);
    abort = 1'b0;
    checkOutput("start_abort_ignored", 64'({csn, busy}), 64'({3'b111, 1'b0}));
    waitUntil(t0 + 8);
    checkOutput("still_idle", 64'({csn, busy}), 64'({3'b111, 1'b0}));

    // Abort at the third edge: no done, then a normal frame
    applyStimulus(2'd0, 1'b0, 1'b0, 8'd1, 6'd2, 4'd0, 4'd0, 4'd0);
    pushExp(4, K_SAMPLE, 1'b1, 3'b110, 1'b1);
    pushExp(6, K_SHIFT,  1'b0, 3'b110, 1'b1);
    pushExp(8, K_SAMPLE, 1'b1, 3'b110, 1'b1);
    waitUntil(t0 + 8);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_outputs", 64'({csn, sck, busy, sample_en, shift_en}),
                64'({3'b111, 1'b0, 1'b0, 1'b0, 1'b0}));
    waitUntil(t0 + 16);
    drainCheck("drain_abort");
    applyStimulus(2'd0, 1'b0, 1'b0, 8'd1, 6'd2, 4'd0, 4'd0, 4'd0);
    pushExp(4,  K_SAMPLE, 1'b1, 3'b110, 1'b1);
    pushExp(6,  K_SHIFT,  1'b0, 3'b110, 1'b1);
    pushExp(8,  K_SAMPLE, 1'b1, 3'b110, 1'b1);
    pushExp(12, K_DONE,   1'b0, 3'b111, 1'b0);
    waitUntil(t0 + 14);
    drainCheck("drain_after_abort");

    // Limits: H=256, one bit, 16-cycle setup/hold/gap, cpha=1
    applyStimulus(2'd1, 1'b0, 1'b1, 8'd255, 6'd0, 4'd15, 4'd15, 4'd15);
    pushExp(273, K_SHIFT,  1'b1, 3'b101, 1'b1);
    pushExp(529, K_SAMPLE, 1'b0, 3'b101, 1'b1);
    pushExp(561, K_DONE,   1'b0, 3'b111, 1'b0);
    waitUntil(t0 + 272);
    checkOutput("limit_c272_sck", 64'(sck), 64'd0);
    waitUntil(t0 + 544);
    checkOutput("limit_c544_csn", 64'(csn), 64'b101);
    waitUntil(t0 + 545);
    checkOutput("limit_c545_csn_busy", 64'({csn, busy}), 64'({3'b111, 1'b1}));
    waitUntil(t0 + 563);
    drainCheck("drain_limits");

    // Asynchronous reset in the middle of XFER
    applyStimulus(2'd2, 1'b0, 1'b0, 8'd1, 6'd2, 4'd0, 4'd0, 4'd0);
    pushExp(4, K_SAMPLE, 1'b1, 3'b011, 1'b1);
    waitUntil(t0 + 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_outputs",
                64'({sck, csn, busy, done, sample_en, shift_en}),
                64'({1'b0, 3'b111, 4'b0000}));
    @(posedge clk);
    #1;
    rst = 1'b0; cpol = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_release", 64'({sck, busy, csn}), 64'({1'b1, 1'b0, 3'b111}));
    drainCheck("drain_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_clkgen.md
SPI_CLKGEN -- requirements
Module: spi_clkgen

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; parameters and ports are REQ-002..REQ-017.
REQ-002 Parameter NUM_CS, default 4: number of chip-select outputs (1..16).
REQ-003 Parameter DIV_W, default 8: width of the clock divider setting.
REQ-004 Parameter CNT_W, default 6: width of the bits-per-frame setting.
REQ-005 Parameter DLY_W, default 4: width of the CS setup, hold and gap settings.
REQ-006 Port clk  in  1: system clock; every register uses its rising edge.
REQ-007 Port rst  in  1: asynchronous active-high reset.
REQ-008 Port start  in  1: one-cycle frame request.
REQ-009 Port abort  in  1: terminates any frame in progress.
REQ-010 Port cs_sel  in  $clog2(NUM_CS) (min 1): target chip select.
REQ-011 Port cpol, cpha  in  1 each: SPI mode bits.
REQ-012 Port div  in  DIV_W: SCK half-period H = div+1 clk cycles.
REQ-013 Port nbits  in  CNT_W: bits per frame; 0 means 1.
REQ-014 Port csn_setup, csn_hold, csn_gap  in  DLY_W each: phase lengths in clk cycles, value+1.
REQ-015 Port sck  out  1: registered serial clock.
REQ-016 Port csn  out  NUM_CS: registered chip selects, active low.
REQ-017 Ports busy, done, sample_en, shift_en  out  1 each: status and one-cycle data strobes.

Function
REQ-018 SHALL use FSM states IDLE, SETUP, XFER, HOLD, GAP; all outputs registered.
REQ-019 In IDLE, csn SHALL be all ones, busy 0, and sck SHALL equal the live cpol with one cycle of latency.
REQ-020 start in IDLE with cs_sel < NUM_CS SHALL latch cs_sel, cpol, cpha, div, nbits, setup, hold and gap, then enter SETUP next cycle with csn[cs_sel]=0 and busy=1.
REQ-021 start while busy, or with cs_sel >= NUM_CS, SHALL be ignored with no output change.
REQ-022 Config input changes after the start cycle SHALL NOT affect the current frame.
REQ-023 SETUP SHALL last csn_setup+1 cycles, then enter XFER.
REQ-024 XFER SHALL produce 2*N sck edges (N = effective nbits), each after H cycles; edge k (k=1..2N) is the k-th sck toggle, and odd k are leading edges.
REQ-025 cpha=0: sample_en SHALL pulse on odd edges and shift_en on even edges except edge 2N; cpha=1: shift_en on odd edges and sample_en on even edges.
REQ-026 Each strobe SHALL be high in exactly the cycle in which the new sck level first appears.
REQ-027 The cycle in which edge 2N appears SHALL be the first HOLD cycle, with sck equal to the latched cpol.
REQ-028 HOLD SHALL last csn_hold+1 cycles; csn SHALL return to all ones in the first GAP cycle.
REQ-029 GAP SHALL last csn_gap+1 cycles, then enter IDLE.
REQ-030 done SHALL pulse for one cycle in the first IDLE cycle after GAP, with busy=0; a start in that cycle SHALL be accepted.
REQ-031 The half-period counter SHALL be DIV_W+1 bits wide so div = all ones gives H = 2^DIV_W with no wrap error; the edge counter SHALL be CNT_W+1 bits wide.
REQ-032 abort in any non-IDLE state SHALL give IDLE on the next cycle: csn all ones, sck = latched cpol, strobes 0, busy 0, and no done pulse.
REQ-033 abort and start in the same IDLE cycle: abort SHALL win, and start is ignored.

Reset
REQ-034 While rst=1: sck=0, csn all ones, busy/done/sample_en/shift_en=0, state IDLE; a reset mid-frame SHALL take effect immediately and asynchronously.
REQ-035 After rst falls, sck SHALL reach cpol on the first clk edge.

Verification
REQ-036 Basic frame: div=1, nbits=2, setup=hold=gap=0, cpol=0, cpha=0, cs_sel=2, start in cycle 0 -> csn[2] low in cycles 1-10; sck toggles visible in cycles 4, 6, 8, 10; sample_en in cycles 4 and 8; shift_en in cycle 6; done and busy=0 in cycle 12.
REQ-037 Mode 3: cpol=1, cpha=1, same settings -> idle sck=1; shift_en in cycles 4 and 8; sample_en in cycles 6 and 10; sck=1 in cycle 10.
REQ-038 Limits: div=255, nbits=0 -> H=256 and exactly 2 edges; setup=hold=gap=15 -> 16-cycle phases.
REQ-039 Abort at the 3rd edge -> next cycle csn all ones, sck=cpol, no done; a new start is then accepted normally.
REQ-040 Rejected starts and reset: start while busy, start with cs_sel=NUM_CS, and start+abort together -> no effect; rst pulsed mid-XFER -> outputs take REQ-034 values within that cycle.
